// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-cycle done/err strobe and a held-low (break) lockout.
// Optional RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency); otherwise RX must already be synchronous to clk.
module uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rx_en,
    output logic [7:0] data,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;
    logic             rxs;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    // Both stages reset high so the line looks idle coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX};
        end
    end

    assign rxs = sync_q[1];
`else
    assign rxs = RX;
`endif

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (!rx_en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!rxs) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q <= '0;
                            if (!rxs) begin
                                state_q <= DATA;
                                idx_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    DATA: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q          <= '0;
                            shift_q[idx_q] <= rxs;
                            if (idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    STOP: begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        if (cnt_q == FULL_M1) begin
                            cnt_q  <= '0;
                            busy_q <= 1'b0;
                            if (rxs) begin
                                data_q  <= shift_q;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= WAIT_HIGH;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxs) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good/bad frames, glitch, enable gating, back-to-back and mid-frame reset.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       rx_line;
    logic       en;
    logic [7:0] data;
    logic       done;
    logic       err;
    logic       busy;

    int         n_tests;
    int         n_fail;
    int         done_cnt;
    int         err_cnt;
    int         both_cnt;
    logic       busy_seen;
    logic       busy_mid;
    logic [7:0] done_log[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .RX    (rx_line),
        .rx_en (en),
        .data  (data),
        .done  (done),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_log.push_back(data);
        end
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame; off_bit drops rx_en at the start of that bit, rst_bit pulses reset mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int off_bit, input int rst_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop_v;
            else v = b[i-1];
            rx_line = v;
            if (i == off_bit) en = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i == 5) busy_mid = busy;
            if (i == rst_bit) begin
                #2 rst = 1'b1;
                #1;
                check_eq("rst_async_data", {24'd0, data}, 32'h00);
                check_eq("rst_async_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_async_done", {31'd0, done}, 32'd0);
                rx_line = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            repeat (CPB - HALF) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    logic [7:0] bytes[8];
    int d0;
    int e0;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        both_cnt  = 0;
        busy_seen = 1'b0;
        busy_mid  = 1'b0;
        bytes     = '{8'h55, 8'hAA, 8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hB4, 8'h6D};
        rst       = 1'b1;
        rx_line   = 1'b1;
        en        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_data", {24'd0, data}, 32'h00);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_err",  {31'd0, err},  32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        foreach (bytes[k]) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(bytes[k], 1'b1, -1, -1);
            repeat (4) @(negedge clk);
            check_eq("good_done_count", done_cnt - d0, 1);
            check_eq("good_err_count", err_cnt - e0, 0);
            check_eq("good_data", {24'd0, data}, {24'd0, bytes[k]});
            check_eq("good_busy_mid", {31'd0, busy_mid}, 32'd1);
            check_eq("good_busy_after", {31'd0, busy}, 32'd0);
        end

        foreach (bytes[k]) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(bytes[k], 1'b0, -1, -1);
            rx_line   = 1'b0;
            busy_seen = 1'b0;
            repeat (3 * CPB) @(negedge clk);
            check_eq("ferr_held_low_busy", {31'd0, busy_seen}, 32'd0);
            rx_line = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            check_eq("ferr_err_count", err_cnt - e0, 1);
            check_eq("ferr_done_count", done_cnt - d0, 0);
            check_eq("ferr_data_kept", {24'd0, data}, 32'h6D);
        end

        d0 = done_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (HALF) @(negedge clk);
        check_eq("glitch_busy_low", {31'd0, busy}, 32'd0);
        check_eq("glitch_busy_rose", {31'd0, busy_seen}, 32'd1);
        repeat (2 * CPB) @(negedge clk);
        check_eq("glitch_done", done_cnt - d0, 0);
        check_eq("glitch_err", err_cnt - e0, 0);
        check_eq("glitch_data", {24'd0, data}, 32'h6D);

        d0 = done_cnt;
        e0 = err_cnt;
        en = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'h3C, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check_eq("disabled_busy", {31'd0, busy_seen}, 32'd0);
        check_eq("disabled_done", done_cnt - d0, 0);
        en = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        send_frame(8'hA5, 1'b1, 5, -1);
        repeat (4) @(negedge clk);
        check_eq("abort_busy_dropped", {31'd0, busy_mid}, 32'd0);
        check_eq("abort_done", done_cnt - d0, 0);
        check_eq("abort_err", err_cnt - e0, 0);
        check_eq("abort_data", {24'd0, data}, 32'h6D);
        en = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        d0 = done_cnt;
        send_frame(8'h12, 1'b1, -1, -1);
        send_frame(8'h34, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check_eq("b2b_done_count", done_cnt - d0, 2);
        if (done_log.size() >= 2) begin
            check_eq("b2b_first",  {24'd0, done_log[done_log.size()-2]}, 32'h12);
            check_eq("b2b_second", {24'd0, done_log[done_log.size()-1]}, 32'h34);
        end else begin
            check_eq("b2b_log_size", done_log.size(), 2);
        end

        d0 = done_cnt;
        send_frame(8'hC3, 1'b1, -1, 6);
        check_eq("rst_done_none", done_cnt - d0, 0);
        repeat (2 * CPB) @(negedge clk);
        check_eq("rst_idle_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, -1, -1);
        repeat (4) @(negedge clk);
        check_eq("post_rst_done", done_cnt - d0, 1);
        check_eq("post_rst_data", {24'd0, data}, 32'h81);

        check_eq("done_err_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
